text_console: RTL
=================

TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 Parameter COLS, default 40: text columns.
REQ-002 Parameter ROWS, default 30: text rows.
REQ-003 Parameter ZOOM, default 1: cell size is 8<<ZOOM pixels square.
REQ-004 px_clk  in  1: single clock; all logic on rising edge.
REQ-005 rstn  in  1: reset, synchronous and active-low.
REQ-006 wr_valid  in  1: host byte offered.
REQ-007 wr_char  in  8: host byte, ASCII or control code.
REQ-008 wr_ready  out  1: console accepts byte this cycle.
REQ-009 px_x  in  10: current pixel X from VGA timing.
REQ-010 px_y  in  10: current pixel Y from VGA timing.
REQ-011 activevideo  in  1: current pixel is visible.
REQ-012 char_code  out  8: registered character for the pixel presented one cycle earlier, fed to the glyph stage.
REQ-013 cursor_col  out  6: current cursor column.
REQ-014 cursor_row  out  5: current cursor row.

Function
REQ-015 The block SHALL hold a COLS*ROWS x 8-bit cell RAM with one write port and one read port; address = row*COLS+col.
REQ-016 Read path SHALL compute col = px_x>>(3+ZOOM) and row = px_y>>(3+ZOOM), then register char_code with exactly 1-cycle latency.
REQ-017 char_code SHALL be 0x00 when activevideo was low or col>=COLS or row>=ROWS in the sampled cycle.
REQ-018 Same-cycle read and write to one address SHALL return the old cell content; the new value SHALL be visible from the next cycle.
REQ-019 A byte transfers only when wr_valid and wr_ready are both high; wr_char is ignored otherwise.
REQ-020 FSM states: CLEAR_ALL, CLEAR_LINE, IDLE; wr_ready SHALL be high only in IDLE.
REQ-021 CLEAR_ALL SHALL write 0x20 to one cell per cycle, from address 0 to COLS*ROWS-1, then set cursor to (0,0) and enter IDLE.
REQ-022 CLEAR_LINE SHALL write 0x20 to the COLS cells of cursor_row, one per cycle, col 0 upward, then enter IDLE with cursor_col=0.
REQ-023 Printable bytes 0x20-0x7E SHALL be written at the cursor and advance cursor_col by 1.
REQ-024 When advancing from col COLS-1, cursor SHALL move to col 0 of the next row and enter CLEAR_LINE.
REQ-025 Newline 0x0A SHALL move to col 0 of the next row and enter CLEAR_LINE.
REQ-026 Row advance from ROWS-1 SHALL wrap to row 0; there is no scrolling.
REQ-027 0x0D SHALL set cursor_col=0, write nothing, stay IDLE.
REQ-028 0x08 SHALL decrement cursor_col, saturating at 0, write nothing.
REQ-029 0x0C SHALL enter CLEAR_ALL.
REQ-030 All other bytes, 0x00-0x1F not listed and 0x7F-0xFF, SHALL be consumed and ignored.
REQ-031 The read path SHALL be independent of FSM state; clearing is visible cell-by-cell as it progresses.

Reset
REQ-032 While rstn=0 at a clock edge: wr_ready=0, char_code=0x00, cursor=(0,0), FSM forced to CLEAR_ALL with the clear address at 0.
REQ-033 After rstn rises, CLEAR_ALL SHALL run COLS*ROWS cycles; wr_ready rises on the following cycle.
REQ-034 Reset asserted mid-CLEAR_LINE or mid-CLEAR_ALL SHALL abandon the clear and restart CLEAR_ALL from address 0.

Verification
REQ-035 Release reset -> wr_ready low for exactly 1200 cycles, then high; every cell reads 0x20.
REQ-036 Write "AB" then scan pixel (x=16,y=0) -> char_code=0x42 one cycle later; cursor=(2,0).
REQ-037 Write 40 x 'Z' -> cursor=(0,1), wr_ready low for 40 cycles, row 1 reads all 0x20.
REQ-038 Cursor at row 29, send 0x0A -> cursor=(0,0), row 0 cleared, rows 1-29 unchanged.
REQ-039 Send 0x08 at col 0 -> cursor stays (0,0). Send 0x07 -> consumed, no RAM change.
REQ-040 Assert activevideo=0, or px_x=640 -> char_code=0x00. Read and write the same cell in one cycle -> old value, then new value on the next cycle.

Source files
------------

// File: rtl/text_console.sv
// Character-cell text console: host bytes update a COLS x ROWS cell RAM through a
// small control FSM, while the pixel scan reads the cell under the beam with one cycle latency.
module text_console #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int ZOOM = 1
) (
  input  logic       px_clk,
  input  logic       rstn,
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  output logic       wr_ready,
  input  logic [9:0] px_x,
  input  logic [9:0] px_y,
  input  logic       activevideo,
  output logic [7:0] char_code,
  output logic [5:0] cursor_col,
  output logic [4:0] cursor_row
);

  localparam int              CELLS     = COLS * ROWS;
  localparam int              AW        = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int              SHIFT     = 3 + ZOOM;
  localparam logic [AW-1:0]   LAST_ADDR = AW'(CELLS - 1);
  localparam logic [5:0]      LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0]      LAST_ROW  = 5'(ROWS - 1);
  localparam logic [9:0]      COLS_PX   = 10'(COLS);
  localparam logic [9:0]      ROWS_PX   = 10'(ROWS);
  localparam logic [7:0]      BLANK     = 8'h20;

  typedef enum logic [1:0] {CLEAR_ALL, CLEAR_LINE, IDLE} state_t;

  state_t          state;
  logic [AW-1:0]   clr_addr;
  logic [5:0]      clr_col;
  logic [7:0]      mem [CELLS];

  logic            accept;
  logic            printable;
  logic [4:0]      next_row;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [7:0]      wdata;

  logic [9:0]      col_px;
  logic [9:0]      row_px;
  logic            rd_valid;
  logic [AW-1:0]   raddr;

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

  assign accept    = wr_valid && wr_ready;
  assign printable = (wr_char >= 8'h20) && (wr_char <= 8'h7E);
  assign next_row  = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;

  // Single RAM write port, shared by the two clear sweeps and printable host bytes.
  always_comb begin
    we    = 1'b0;
    waddr = clr_addr;
    wdata = BLANK;
    case (state)
      CLEAR_ALL: begin
        we    = 1'b1;
        waddr = clr_addr;
      end
      CLEAR_LINE: begin
        we    = 1'b1;
        waddr = cell_addr(cursor_row, clr_col);
      end
      IDLE: begin
        if (accept && printable) begin
          we    = 1'b1;
          waddr = cell_addr(cursor_row, cursor_col);
          wdata = wr_char;
        end
      end
      default: we = 1'b0;
    endcase
    if (!rstn) we = 1'b0;
  end

  always_ff @(posedge px_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign col_px   = px_x >> SHIFT;
  assign row_px   = px_y >> SHIFT;
  assign rd_valid = activevideo && (col_px < COLS_PX) && (row_px < ROWS_PX);
  assign raddr    = rd_valid ? (AW'(row_px) * AW'(COLS) + AW'(col_px)) : '0;

  // Read before write: a same-cycle write to this cell shows up one cycle later.
  always_ff @(posedge px_clk) begin
    if (!rstn) char_code <= 8'h00;
    else       char_code <= rd_valid ? mem[raddr] : 8'h00;
  end

  always_ff @(posedge px_clk) begin
    if (!rstn) begin
      state      <= CLEAR_ALL;
      clr_addr   <= '0;
      clr_col    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      wr_ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR_ALL: begin
          if (clr_addr == LAST_ADDR) begin
            state      <= IDLE;
            wr_ready   <= 1'b1;
            clr_addr   <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
          end else begin
            clr_addr <= clr_addr + AW'(1);
          end
        end
        CLEAR_LINE: begin
          if (clr_col == LAST_COL) begin
            state      <= IDLE;
            wr_ready   <= 1'b1;
            clr_col    <= '0;
            cursor_col <= '0;
          end else begin
            clr_col <= clr_col + 6'd1;
          end
        end
        IDLE: begin
          if (accept) begin
            if (printable) begin
              if (cursor_col == LAST_COL) begin
                cursor_col <= '0;
                cursor_row <= next_row;
                state      <= CLEAR_LINE;
                clr_col    <= '0;
                wr_ready   <= 1'b0;
              end else begin
                cursor_col <= cursor_col + 6'd1;
              end
            end else begin
              case (wr_char)
                8'h0A: begin
                  cursor_col <= '0;
                  cursor_row <= next_row;
                  state      <= CLEAR_LINE;
                  clr_col    <= '0;
                  wr_ready   <= 1'b0;
                end
                8'h0D: cursor_col <= '0;
                8'h08: if (cursor_col != 6'd0) cursor_col <= cursor_col - 6'd1;
                8'h0C: begin
                  state    <= CLEAR_ALL;
                  clr_addr <= '0;
                  wr_ready <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
        default: begin
          state    <= CLEAR_ALL;
          clr_addr <= '0;
          wr_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
